spi_slave_regif: RTL and testbench

SPI slave front end that turns framed SPI transactions from the STM host into single-cycle register-bus accesses in the `sys_clk` domain. It sits directly upstream of the slot register bank: GPIO output/input/direction, interrupt status/mask/clear, and the SPI-master control registers. Frame format is R/~W bit, 7-bit address MSB first, `DUMMY_CYCLES` idle clocks, then 16 data bits MSB first. All SPI pins are oversampled; there is no second clock domain.

---
 rtl/spi_regif_pkg.sv | 23 ++
 rtl/spi_in_sync.sv | 54 +++++
 rtl/spi_slave_regif.sv | 201 ++++++++++++++++++++
 tb/tb_spi_slave_regif.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/spi_regif_pkg.sv
// Shared types and sizing helpers for the SPI slave register interface.
package spi_regif_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_DUMMY,
    ST_WAIT_RD,
    ST_DATA,
    ST_DONE
  } spi_state_e;

  localparam int CMD_W = 8;

  function automatic int bit_cnt_w(input int data_w, input int dummy_cycles);
    int m;
    m = (data_w > dummy_cycles) ? data_w : dummy_cycles;
    return $clog2(m + 1);
  endfunction

  localparam int BIT_CNT_W = bit_cnt_w(16, 8);

endpackage

// File: rtl/spi_in_sync.sv
// Two-flop synchronisers for the SPI pins plus registered edge pulses on SCLK and CS_n.
module spi_in_sync (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_sclk,
  input  logic i_mosi,
  input  logic i_cs_n,
  output logic o_sclk_rise,
  output logic o_sclk_fall,
  output logic o_mosi,
  output logic o_cs_n,
  output logic o_cs_rise,
  output logic o_cs_fall
);

  // [0] first stage, [1] synchronised level, [2] previous synchronised level.
  // CS_n resets to "selected" so a frame already in flight at reset release
  // produces no falling edge and is ignored until CS_n is seen high again.
  logic [2:0] r_sclk;
  logic [2:0] r_cs;
  logic [1:0] r_mosi;
  logic       r_sclk_rise;
  logic       r_sclk_fall;
  logic       r_cs_rise;
  logic       r_cs_fall;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sclk      <= '0;
      r_cs        <= '0;
      r_mosi      <= '0;
      r_sclk_rise <= 1'b0;
      r_sclk_fall <= 1'b0;
      r_cs_rise   <= 1'b0;
      r_cs_fall   <= 1'b0;
    end else begin
      r_sclk      <= {r_sclk[1:0], i_sclk};
      r_cs        <= {r_cs[1:0], i_cs_n};
      r_mosi      <= {r_mosi[0], i_mosi};
      r_sclk_rise <= r_sclk[1] & ~r_sclk[2];
      r_sclk_fall <= ~r_sclk[1] & r_sclk[2];
      r_cs_rise   <= r_cs[1] & ~r_cs[2];
      r_cs_fall   <= ~r_cs[1] & r_cs[2];
    end
  end

  assign o_sclk_rise = r_sclk_rise;
  assign o_sclk_fall = r_sclk_fall;
  assign o_mosi      = r_mosi[1];
  assign o_cs_n      = r_cs[1];
  assign o_cs_rise   = r_cs_rise;
  assign o_cs_fall   = r_cs_fall;

endmodule

// File: rtl/spi_slave_regif.sv
// SPI mode-0 slave that turns {R/~W, addr, dummy, data} frames into one-cycle
// register-bus strobes, all on sys_clk with oversampled SPI pins.
module spi_slave_regif
  import spi_regif_pkg::*;
#(
  parameter int ADDR_W       = 7,
  parameter int DATA_W       = 16,
  parameter int DUMMY_CYCLES = 8
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic              spi_clk,
  input  logic              spi_mosi,
  input  logic              spi_cs_n,
  output logic              spi_miso,
  output logic              spi_miso_oe,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  output logic              bus_we,
  output logic              bus_re,
  input  logic [DATA_W-1:0] bus_rdata,
  input  logic              bus_rvalid,
  output logic              rd_timeout,
  output logic              frame_err,
  output spi_state_e        dbg_state
);

  localparam int CNT_W = bit_cnt_w(DATA_W, DUMMY_CYCLES);
  localparam logic [CNT_W-1:0] CMD_LAST   = CNT_W'(CMD_W - 1);
  localparam logic [CNT_W-1:0] DUMMY_LAST = CNT_W'(DUMMY_CYCLES - 1);
  localparam logic [CNT_W-1:0] DATA_LAST  = CNT_W'(DATA_W - 1);

  logic w_sclk_rise, w_sclk_fall, w_mosi, w_cs_n, w_cs_rise, w_cs_fall;

  spi_in_sync u_sync (
    .i_clk       (sys_clk),
    .i_rst_n     (sys_rst_n),
    .i_sclk      (spi_clk),
    .i_mosi      (spi_mosi),
    .i_cs_n      (spi_cs_n),
    .o_sclk_rise (w_sclk_rise),
    .o_sclk_fall (w_sclk_fall),
    .o_mosi      (w_mosi),
    .o_cs_n      (w_cs_n),
    .o_cs_rise   (w_cs_rise),
    .o_cs_fall   (w_cs_fall)
  );

  spi_state_e        r_state, w_next;
  logic [CNT_W-1:0]  r_bit_cnt;
  logic [CMD_W-1:0]  r_cmd;
  logic [DATA_W-1:0] r_rx, r_tx;
  logic              r_rnw, r_armed, r_rd_pend, r_rd_got;
  logic              r_bus_re, r_bus_we, r_frame_err, r_miso_oe, r_rd_timeout;
  logic [ADDR_W-1:0] r_bus_addr;
  logic [DATA_W-1:0] r_bus_wdata;
  logic              w_latch, w_enter_data, w_last_rx, w_abort, w_rd_hit;
  logic [CMD_W-1:0]  w_cmd_next;
  logic [DATA_W-1:0] w_rx_next;

  // Read handshake: bus_re is a one-cycle request; the bank answers with a
  // one-cycle bus_rvalid carrying bus_rdata. Only the first rvalid between the
  // request and DATA entry is taken; anything later is dropped.
  assign w_rd_hit   = r_rd_pend & bus_rvalid;
  assign w_cmd_next = {r_cmd[CMD_W-2:0], w_mosi};
  assign w_rx_next  = {r_rx[DATA_W-2:0], w_mosi};

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) r_state <= ST_IDLE;
    else            r_state <= w_next;
  end

  always_comb begin
    w_next       = r_state;
    w_latch      = 1'b0;
    w_enter_data = 1'b0;
    w_last_rx    = 1'b0;
    w_abort      = 1'b0;
    case (r_state)
      ST_IDLE: if (r_armed && w_cs_fall) w_next = ST_CMD;
      ST_CMD: begin
        if (w_cs_rise) begin
          w_abort = 1'b1;
          w_next  = ST_IDLE;
        end else if (w_sclk_rise && r_bit_cnt == CMD_LAST) begin
          w_latch = 1'b1;
          w_next  = ST_DUMMY;
        end
      end
      ST_DUMMY: begin
        if (w_cs_rise) begin
          w_abort = 1'b1;
          w_next  = ST_IDLE;
        end else if (DUMMY_CYCLES == 0) begin
          if (r_rnw && !r_rd_got && !w_rd_hit) begin
            w_next = ST_WAIT_RD;
          end else begin
            w_enter_data = 1'b1;
            w_next       = ST_DATA;
          end
        end else if (w_sclk_rise && r_bit_cnt == DUMMY_LAST) begin
          w_enter_data = 1'b1;
          w_next       = ST_DATA;
        end
      end
      ST_WAIT_RD: begin
        if (w_cs_rise) begin
          w_abort = 1'b1;
          w_next  = ST_IDLE;
        end else if (w_rd_hit) begin
          w_enter_data = 1'b1;
          w_next       = ST_DATA;
        end
      end
      ST_DATA: begin
        if (w_cs_rise) begin
          w_abort = 1'b1;
          w_next  = ST_IDLE;
        end else if (w_sclk_rise && r_bit_cnt == DATA_LAST) begin
          w_last_rx = 1'b1;
          w_next    = ST_DONE;
        end
      end
      ST_DONE: if (w_cs_rise) w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_bit_cnt    <= '0;
      r_cmd        <= '0;
      r_rx         <= '0;
      r_tx         <= '0;
      r_rnw        <= 1'b0;
      r_armed      <= 1'b0;
      r_rd_pend    <= 1'b0;
      r_rd_got     <= 1'b0;
      r_bus_re     <= 1'b0;
      r_bus_we     <= 1'b0;
      r_frame_err  <= 1'b0;
      r_miso_oe    <= 1'b0;
      r_rd_timeout <= 1'b0;
      r_bus_addr   <= '0;
      r_bus_wdata  <= '0;
    end else begin
      r_bus_re    <= w_latch & w_cmd_next[CMD_W-1];
      r_bus_we    <= w_last_rx & ~r_rnw;
      r_frame_err <= w_abort;
      r_miso_oe   <= r_armed & ~w_cs_n;
      if (w_cs_n) r_armed <= 1'b1;

      if (w_latch || w_enter_data || r_state == ST_IDLE)
        r_bit_cnt <= '0;
      else if (w_sclk_rise && (r_state == ST_CMD || r_state == ST_DUMMY || r_state == ST_DATA))
        r_bit_cnt <= r_bit_cnt + 1'b1;

      if (r_state == ST_IDLE) begin
        r_cmd     <= '0;
        r_rx      <= '0;
        r_rd_pend <= 1'b0;
      end
      if (r_state == ST_CMD && w_sclk_rise) r_cmd <= w_cmd_next;

      if (w_latch) begin
        r_rnw      <= w_cmd_next[CMD_W-1];
        r_bus_addr <= w_cmd_next[ADDR_W-1:0];
        r_tx       <= '0;
        r_rd_got   <= 1'b0;
        r_rd_pend  <= w_cmd_next[CMD_W-1];
      end
      if (w_rd_hit) begin
        r_tx      <= bus_rdata;
        r_rd_got  <= 1'b1;
        r_rd_pend <= 1'b0;
      end
      if (w_enter_data) begin
        r_rd_pend <= 1'b0;
        if (r_rnw && !r_rd_got && !w_rd_hit) r_rd_timeout <= 1'b1;
      end

      // Bit 15 is already on MISO at DATA entry, so the fall that closes the
      // last dummy cycle must not shift; shifting starts after the first data rise.
      if (r_state == ST_DATA && w_sclk_fall && r_bit_cnt != '0)
        r_tx <= {r_tx[DATA_W-2:0], 1'b0};
      if (r_state == ST_DATA && w_sclk_rise) r_rx <= w_rx_next;
      if (w_last_rx && !r_rnw) r_bus_wdata <= w_rx_next;
    end
  end

  assign spi_miso    = (r_state == ST_DATA) & r_tx[DATA_W-1];
  assign spi_miso_oe = r_miso_oe;
  assign bus_addr    = r_bus_addr;
  assign bus_wdata   = r_bus_wdata;
  assign bus_we      = r_bus_we;
  assign bus_re      = r_bus_re;
  assign rd_timeout  = r_rd_timeout;
  assign frame_err   = r_frame_err;
  assign dbg_state   = r_state;

endmodule

// File: tb/tb_spi_slave_regif.sv
// Bench for spi_slave_regif: SPI master tasks, one-cycle register responder,
// bus-event scoreboard, table of frames plus abort / reset / back-to-back sequences.
module tb_spi_slave_regif;
  import spi_regif_pkg::*;

  localparam int HALF_NOM = 5;
  localparam int HALF_MIN = 3;

  logic        sys_clk    = 1'b0;
  logic        sys_rst_n  = 1'b0;
  logic        spi_clk    = 1'b0;
  logic        spi_mosi   = 1'b0;
  logic        spi_cs_n   = 1'b1;
  logic        spi_miso, spi_miso_oe;
  logic [6:0]  bus_addr;
  logic [15:0] bus_wdata;
  logic        bus_we, bus_re;
  logic [15:0] bus_rdata  = '0;
  logic        bus_rvalid = 1'b0;
  logic        rd_timeout, frame_err;
  spi_state_e  dbg_state;

  // clock / reset
  always #5 sys_clk = ~sys_clk;

  spi_slave_regif #(.ADDR_W(7), .DATA_W(16), .DUMMY_CYCLES(8)) dut (
    .sys_clk     (sys_clk),
    .sys_rst_n   (sys_rst_n),
    .spi_clk     (spi_clk),
    .spi_mosi    (spi_mosi),
    .spi_cs_n    (spi_cs_n),
    .spi_miso    (spi_miso),
    .spi_miso_oe (spi_miso_oe),
    .bus_addr    (bus_addr),
    .bus_wdata   (bus_wdata),
    .bus_we      (bus_we),
    .bus_re      (bus_re),
    .bus_rdata   (bus_rdata),
    .bus_rvalid  (bus_rvalid),
    .rd_timeout  (rd_timeout),
    .frame_err   (frame_err),
    .dbg_state   (dbg_state)
  );

  int checks = 0;
  int errors = 0;
  int fe_cnt = 0;
  logic [23:0] exp_q[$];
  logic [23:0] mon_act;
  logic        resp_en   = 1'b0;
  logic [15:0] resp_data = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // register bank model: answers one cycle after bus_re when enabled
  always @(posedge sys_clk) begin
    bus_rvalid <= 1'b0;
    if (bus_re && resp_en) begin
      bus_rvalid <= 1'b1;
      bus_rdata  <= resp_data;
    end
  end

  // scoreboard: every strobe must match the head of exp_q
  always @(negedge sys_clk) begin
    if (sys_rst_n) begin
      if (frame_err) fe_cnt++;
      if (bus_we || bus_re) begin
        mon_act = bus_re ? {1'b1, bus_addr, 16'h0000} : {1'b0, bus_addr, bus_wdata};
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_strobe: got 0x%0h, expected no strobe", mon_act);
        end else begin
          chk("bus_event", mon_act, exp_q.pop_front());
        end
      end
    end
  end

  // driver tasks
  task automatic cyc(input int n);
    repeat (n) @(negedge sys_clk);
  endtask

  task automatic sbit(input logic b, input int half, output logic m);
    spi_mosi = b;
    cyc(half);
    m = spi_miso;
    spi_clk = 1'b1;
    cyc(half);
    spi_clk = 1'b0;
  endtask

  task automatic frame(input logic rnw, input logic [6:0] addr, input logic [15:0] wdata,
                       input int half, input int data_bits, input int extra,
                       output logic [15:0] rd);
    logic [7:0] cmd;
    logic m;
    cmd = {rnw, addr};
    rd = '0;
    spi_cs_n = 1'b0;
    for (int i = 7; i >= 0; i--) sbit(cmd[i], half, m);
    chk("miso_oe_active", spi_miso_oe, 1);
    for (int i = 0; i < 8; i++) sbit(1'b0, half, m);
    for (int i = 0; i < data_bits; i++) begin
      sbit(wdata[15-i], half, m);
      rd = {rd[14:0], m};
    end
    for (int i = 0; i < extra; i++) sbit(1'b1, half, m);
    cyc(half);
    spi_cs_n = 1'b1;
    spi_mosi = 1'b0;
  endtask

  task automatic push_event(input logic rnw, input logic [6:0] addr, input logic [15:0] wdata);
    exp_q.push_back(rnw ? {1'b1, addr, 16'h0000} : {1'b0, addr, wdata});
  endtask

  typedef struct {
    logic        rnw;
    logic [6:0]  addr;
    logic [15:0] wdata;
    logic        resp_en;
    logic [15:0] resp;
    logic [15:0] exp_rd;
    logic        exp_to;
  } vec_t;

  vec_t vecs[8];

  initial begin
    logic [15:0] rd;
    logic [15:0] r0, r1, r2;
    logic        m;
    int          fe0;

    r0 = 16'($urandom_range(0, 65535));
    r1 = 16'($urandom_range(0, 65535));
    r2 = 16'($urandom_range(0, 65535));
    vecs[0] = '{1'b0, 7'h00, 16'hAAAA, 1'b0, 16'h0000, 16'h0000, 1'b0};
    vecs[1] = '{1'b1, 7'h01, 16'h0000, 1'b1, 16'h5555, 16'h5555, 1'b0};
    vecs[2] = '{1'b0, 7'h7F, r0,       1'b0, 16'h0000, 16'h0000, 1'b0};
    vecs[3] = '{1'b1, 7'h7E, 16'h0000, 1'b1, 16'hA5C3, 16'hA5C3, 1'b0};
    vecs[4] = '{1'b1, 7'h02, 16'h0000, 1'b0, 16'hDEAD, 16'h0000, 1'b1};
    vecs[5] = '{1'b1, 7'h03, 16'h0000, 1'b1, 16'h1357, 16'h1357, 1'b1};
    vecs[6] = '{1'b0, 7'h2A, r1,       1'b0, 16'h0000, 16'h0000, 1'b1};
    vecs[7] = '{1'b1, 7'h40, 16'h0000, 1'b1, r2,       r2,       1'b1};

    // reset state
    cyc(3);
    chk("rst_miso", spi_miso, 0);
    chk("rst_miso_oe", spi_miso_oe, 0);
    chk("rst_bus_addr", bus_addr, 0);
    chk("rst_bus_wdata", bus_wdata, 0);
    chk("rst_strobes", {bus_we, bus_re, frame_err, rd_timeout}, 0);
    chk("rst_state", dbg_state, ST_IDLE);
    sys_rst_n = 1'b1;
    cyc(6);

    for (int i = 0; i < 8; i++) begin
      resp_en   = vecs[i].resp_en;
      resp_data = vecs[i].resp;
      push_event(vecs[i].rnw, vecs[i].addr, vecs[i].wdata);
      fe0 = fe_cnt;
      frame(vecs[i].rnw, vecs[i].addr, vecs[i].wdata, HALF_NOM, 16, 0, rd);
      cyc(6);
      if (vecs[i].rnw) chk("read_data", rd, vecs[i].exp_rd);
      chk("rd_timeout", rd_timeout, vecs[i].exp_to);
      chk("events_done", exp_q.size(), 0);
      chk("no_frame_err", fe_cnt, fe0);
      chk("miso_oe_idle", spi_miso_oe, 0);
      chk("state_idle", dbg_state, ST_IDLE);
    end

    // abort after 10 data bits, then a normal write
    resp_en = 1'b1;
    fe0 = fe_cnt;
    frame(1'b0, 7'h04, 16'hFFFF, HALF_NOM, 10, 0, rd);
    cyc(6);
    chk("abort_frame_err", fe_cnt, fe0 + 1);
    chk("abort_no_we", exp_q.size(), 0);
    push_event(1'b0, 7'h05, 16'h1234);
    frame(1'b0, 7'h05, 16'h1234, HALF_NOM, 16, 0, rd);
    cyc(6);
    chk("post_abort_write", exp_q.size(), 0);

    // reset during the dummy phase of a write to 0x06
    fe0 = fe_cnt;
    spi_cs_n = 1'b0;
    for (int i = 7; i >= 0; i--) sbit(i == 7 ? 1'b0 : ((7'h06 >> i) & 1'b1), HALF_NOM, m);
    for (int i = 0; i < 3; i++) sbit(1'b0, HALF_NOM, m);
    sys_rst_n = 1'b0;
    cyc(1);
    chk("midrst_bus_addr", bus_addr, 0);
    chk("midrst_bus_wdata", bus_wdata, 0);
    chk("midrst_outputs", {spi_miso, spi_miso_oe, bus_we, bus_re, rd_timeout, frame_err}, 0);
    chk("midrst_state", dbg_state, ST_IDLE);
    cyc(2);
    sys_rst_n = 1'b1;
    for (int i = 0; i < 5; i++) sbit(1'b0, HALF_NOM, m);
    for (int i = 0; i < 16; i++) sbit(i[0], HALF_NOM, m);
    chk("midrst_oe_quiet", spi_miso_oe, 0);
    cyc(HALF_NOM);
    spi_cs_n = 1'b1;
    cyc(8);
    chk("midrst_no_strobes", exp_q.size(), 0);
    chk("midrst_no_frame_err", fe_cnt, fe0);
    chk("midrst_timeout_clear", rd_timeout, 0);
    push_event(1'b0, 7'h06, 16'hC001);
    frame(1'b0, 7'h06, 16'hC001, HALF_NOM, 16, 0, rd);
    cyc(6);
    chk("post_rst_write", exp_q.size(), 0);

    // back-to-back frames at minimum SCLK period, extra clocks after the first
    fe0 = fe_cnt;
    push_event(1'b0, 7'h08, 16'hBEEF);
    push_event(1'b0, 7'h09, 16'h0F0F);
    frame(1'b0, 7'h08, 16'hBEEF, HALF_MIN, 16, 3, rd);
    cyc(2);
    frame(1'b0, 7'h09, 16'h0F0F, HALF_MIN, 16, 0, rd);
    cyc(8);
    chk("b2b_events", exp_q.size(), 0);
    chk("b2b_no_frame_err", fe_cnt, fe0);
    chk("b2b_last_wdata", bus_wdata, 16'h0F0F);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
